aes_cipher_arb: RTL and testbench

- Round-robin arbiter that shares one pipelined AES cipher core between NREQ requesters.
- Forwards each accepted plaintext block to the core with a one-cycle load pulse and tracks the requester ID through an internal tag delay line matched to the core latency.
- Buffers finished ciphertext in a response FIFO with valid/ready backpressure. The core cannot stall, so a credit counter only issues blocks that already have a reserved FIFO slot.

---
 rtl/aes_cipher_arb.sv | 161 ++++++++++++++++
 tb/tb_aes_cipher_arb.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_cipher_arb.sv
// Round-robin front end that shares one pipelined AES cipher core between NREQ requesters.
// Optional AES_CIPHER_ARB_CHK_EN adds a sticky core/tag alignment check driving err.
module aes_cipher_arb #(
    parameter int NREQ       = 4,
    parameter int Nk         = 4,
    parameter int Nr         = Nk + 6,
    parameter int LAT        = Nr + 1,
    parameter int FIFO_DEPTH = 16,
    parameter int IDW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*128-1:0] req_pt,
    output logic [NREQ-1:0]     req_ready,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [127:0]        rsp_ct,
    output logic [IDW-1:0]      rsp_id,
    output logic                cph_load,
    output logic [127:0]        cph_pt,
    input  logic [127:0]        cph_ct,
    input  logic                cph_valid,
    output logic                busy,
    output logic                err
);
    localparam int              CW        = $clog2(FIFO_DEPTH + 1);
    localparam int              PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [IDW:0]    NREQ_W    = (IDW + 1)'(NREQ);
    localparam logic [CW:0]     DEPTH_W   = (CW + 1)'(FIFO_DEPTH);
    localparam logic [PW-1:0]   LAST_SLOT = PW'(FIFO_DEPTH - 1);

    typedef struct packed {
        logic           vld;
        logic [IDW-1:0] id;
    } tag_t;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [127:0]   ct;
    } rsp_t;

    logic [NREQ-1:0][127:0] pt_arr;
    logic [IDW-1:0]         ptr;
    logic [IDW-1:0]         grant_id;
    logic [IDW-1:0]         load_id;
    logic [IDW:0]           cand;
    logic                   found;
    logic                   credit_ok;
    logic                   hs;
    logic                   wr;
    logic                   rd;
    logic [CW-1:0]          inflight;
    logic [CW-1:0]          count;
    logic [CW:0]            outstanding;
    tag_t                   tag_line [LAT];
    tag_t                   tag_out;
    rsp_t                   mem [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;

    assign pt_arr = req_pt;

    // Every issued block owns a FIFO slot from grant until pop, since the core cannot stall.
    assign outstanding = {1'b0, inflight} + {1'b0, count};
    assign credit_ok   = outstanding < DEPTH_W;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        req_ready = '0;
        grant_id  = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = {1'b0, ptr} + (IDW + 1)'(k);
            if (cand >= NREQ_W) cand = cand - NREQ_W;
            if (!found && req_valid[cand[IDW-1:0]]) begin
                found    = 1'b1;
                grant_id = cand[IDW-1:0];
            end
        end
        if (found && credit_ok && !rst) req_ready[grant_id] = 1'b1;
    end

    assign hs = |(req_valid & req_ready);

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= IDW'(NREQ - 1);
            cph_load <= 1'b0;
            cph_pt   <= '0;
            load_id  <= '0;
            inflight <= '0;
        end else begin
            cph_load <= hs;
            if (hs) begin
                ptr     <= grant_id;
                load_id <= grant_id;
                cph_pt  <= pt_arr[grant_id];
            end
            inflight <= inflight + CW'(hs) - CW'(tag_out.vld);
        end
    end

    // Fed from the registered load so the tag exits exactly when the core presents the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < LAT; s++) tag_line[s] <= '0;
        end else begin
            tag_line[0] <= {cph_load, load_id};
            for (int s = 1; s < LAT; s++) tag_line[s] <= tag_line[s-1];
        end
    end

    assign tag_out = tag_line[LAT-1];

`ifdef AES_CIPHER_ARB_CHK_EN
    logic err_q;

    assign wr = cph_valid & tag_out.vld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (cph_valid != tag_out.vld) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign wr  = cph_valid;
    assign err = 1'b0;
`endif

    assign rd = rsp_valid & rsp_ready;

    // NOTE: FIFO storage is deliberately not reset; validity is carried entirely by count.
    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= {tag_out.id, cph_ct};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr) wr_ptr <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + 1'b1;
            if (rd) rd_ptr <= (rd_ptr == LAST_SLOT) ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(wr) - CW'(rd);
        end
    end

    assign rsp_valid = (count != '0);
    assign rsp_id    = mem[rd_ptr].id;
    assign rsp_ct    = mem[rd_ptr].ct;
    assign busy      = (inflight != '0) | (count != '0) | cph_load;

endmodule

// File: tb/tb_aes_cipher_arb.sv
// Bench for aes_cipher_arb: AES-128 core model plus a transaction-level model of grants and responses.
`timescale 1ns/1ps
module tb_aes_cipher_arb;
    localparam int NREQ  = 4;
    localparam int LAT   = 11;
    localparam int DEPTH = 16;
    localparam int IDW   = 2;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*128-1:0] req_pt;
    logic [NREQ-1:0]     req_ready;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [127:0]        rsp_ct;
    logic [IDW-1:0]      rsp_id;
    logic                cph_load;
    logic [127:0]        cph_pt;
    logic [127:0]        cph_ct;
    logic                cph_valid;
    logic                busy;
    logic                err;
    logic                spur;
    logic [127:0]        pts [NREQ];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    aes_cipher_arb dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_pt    (req_pt),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_ct    (rsp_ct),
        .rsp_id    (rsp_id),
        .cph_load  (cph_load),
        .cph_pt    (cph_pt),
        .cph_ct    (cph_ct),
        .cph_valid (cph_valid),
        .busy      (busy),
        .err       (err)
    );

    always_comb begin
        req_pt = '0;
        for (int i = 0; i < NREQ; i++) req_pt[128*i +: 128] = pts[i];
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- AES-128 reference ----------------
    logic [7:0] sbox [256];
    logic [7:0] rk [11][16];

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = xt(a);
        end
        return p;
    endfunction

    task automatic build_tables();
        logic [7:0]  inv;
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                      {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
        for (int i = 0; i < 4; i++) w[i] = FIPS_KEY[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]], sbox[tmp[31:24]]} ^ {rc, 24'h0};
                rc  = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++)
            for (int c = 0; c < 4; c++)
                for (int j = 0; j < 4; j++)
                    rk[r][4*c+j] = w[4*r+c][31-8*j -: 8];
    endtask

    function automatic logic [127:0] aes_enc(input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[0][i];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
            for (int c = 0; c < 4; c++)
                for (int j = 0; j < 4; j++)
                    s[j+4*c] = t[j+4*((c+j)%4)];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[r][i];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- cipher core model (fixed latency, cleared by reset) ----------------
    logic         pv [LAT];
    logic [127:0] pd [LAT];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < LAT; s++) pv[s] <= 1'b0;
        end else begin
            pv[0] <= cph_load;
            pd[0] <= cph_load ? aes_enc(cph_pt) : 128'h0;
            for (int s = 1; s < LAT; s++) begin
                pv[s] <= pv[s-1];
                pd[s] <= pd[s-1];
            end
        end
    end

    assign cph_valid = pv[LAT-1] | spur;
    assign cph_ct    = pd[LAT-1];

    // ---------------- transaction-level model and per-cycle compare ----------------
    typedef struct {
        int           id;
        logic [127:0] ct;
        int           t_vis;
    } exp_t;

    exp_t         q [$];
    int           dut_glog [$];
    int           cyc      = 0;
    int           hs_count = 0;
    int           pops     = 0;
    int           ptr_m    = NREQ - 1;
    logic         load_m   = 1'b0;
    logic         err_m    = 1'b0;
    logic [127:0] pt_m     = '0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        int              g;
        int              ii;
        logic [NREQ-1:0] g_vec;
        logic            rv_m;
        for (int i = 0; i < NREQ; i++)
            if (req_valid[i] && req_ready[i]) begin
                dut_glog.push_back(i);
                hs_count++;
            end
        if (rsp_valid && rsp_ready) pops++;
        if (rst) begin
            check("rst_req_ready", req_ready, 0);
            check("rst_cph_load", cph_load, 0);
            check("rst_cph_pt", cph_pt, 0);
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_busy", busy, 0);
            check("rst_err", err, 0);
            q.delete();
            ptr_m  = NREQ - 1;
            load_m = 1'b0;
            pt_m   = '0;
            err_m  = 1'b0;
        end else begin
            g = -1;
            if (q.size() < DEPTH)
                for (int k = 1; k <= NREQ; k++) begin
                    ii = (ptr_m + k) % NREQ;
                    if (g < 0 && req_valid[ii]) g = ii;
                end
            g_vec = '0;
            if (g >= 0) g_vec[g] = 1'b1;
            rv_m = (q.size() > 0) && (q[0].t_vis <= cyc);
            check("req_ready", req_ready, g_vec);
            check("cph_load", cph_load, load_m);
            check("cph_pt", cph_pt, pt_m);
            check("rsp_valid", rsp_valid, rv_m);
            if (rv_m) begin
                check("rsp_ct", rsp_ct, q[0].ct);
                check("rsp_id", rsp_id, q[0].id);
            end
            check("busy", busy, q.size() != 0);
            check("err", err, err_m);
            if (rv_m && rsp_ready) void'(q.pop_front());
            load_m = (g >= 0);
            if (g >= 0) begin
                pt_m = pts[g];
                q.push_back('{g, aes_enc(pt_m), cyc + LAT + 2});
                ptr_m = g;
            end
`ifdef AES_CIPHER_ARB_CHK_EN
            if (spur) err_m = 1'b1;
`endif
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic drain();
        int n;
        req_valid = '0;
        rsp_ready = 1'b1;
        n = 0;
        while (busy && n < 300) begin
            step();
            n++;
        end
        check("drain_done", busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion before 2ms");
        $fatal(1);
    end

    initial begin
        int lat;
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        spur      = 1'b0;
        for (int i = 0; i < NREQ; i++) pts[i] = '0;
        build_tables();
        check("aes_fips_model", aes_enc(FIPS_PT), FIPS_CT);

        repeat (3) step();
        rst = 1'b0;

        // single FIPS-197 block, latency and content pinned by literals
        pts[0]    = FIPS_PT;
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        at_neg();
        check("single_grant", req_ready, 4'b0001);
        step();
        req_valid = '0;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            step();
            lat++;
        end
        check("single_latency", lat, 13);
        check("single_ct", rsp_ct, FIPS_CT);
        check("single_id", rsp_id, 0);
        step();
        step();
        check("single_idle", busy, 0);

        // round robin with all requesters valid
        do_reset();
        dut_glog.delete();
        req_valid = '1;
        rsp_ready = 1'b1;
        repeat (12) begin
            for (int i = 0; i < NREQ; i++) pts[i] = rand128();
            step();
        end
        req_valid = '0;
        check("rr_grant_count", dut_glog.size(), 12);
        for (int i = 0; i < 8; i++) check($sformatf("rr_order%0d", i), dut_glog[i], i % 4);
        drain();

        // backpressure: credit caps outstanding blocks at the FIFO depth
        rsp_ready = 1'b0;
        hs_count  = 0;
        pops      = 0;
        req_valid = 4'b0100;
        repeat (30) begin
            pts[2] = rand128();
            step();
        end
        at_neg();
        check("bp_grants", hs_count, 16);
        check("bp_stalled", req_ready, 0);
        step();
        rsp_ready = 1'b1;
        at_neg();
        check("bp_no_same_cycle_grant", req_ready, 0);
        step();
        rsp_ready = 1'b0;
        at_neg();
        check("bp_regrant", req_ready, 4'b0100);
        step();
        req_valid = '0;
        at_neg();
        check("bp_total", hs_count, 17);

        // result lands on a 15-entry FIFO while the head is popped
        lat = 0;
        while (!cph_valid && lat < 30) begin
            step();
            lat++;
        end
        check("fullwp_arrival", cph_valid, 1);
        rsp_ready = 1'b1;
        at_neg();
        check("fullwp_rsp_valid", rsp_valid, 1);
        drain();
        check("bp_pop_count", pops, 17);

        // randomized traffic with bursty backpressure
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < NREQ; i++) pts[i] = rand128();
            if (c % 500 < 250) req_valid = NREQ'($urandom);
            else               req_valid = NREQ'($urandom & $urandom);
            rsp_ready = (c % 200 < 140) ? ($urandom_range(0, 3) != 0) : 1'b0;
            step();
        end
        drain();

        // reset with 5 blocks in flight and 3 in the FIFO
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        repeat (8) begin
            pts[0] = rand128();
            step();
        end
        req_valid = '0;
        repeat (7) step();
        check("midrst_pre_valid", rsp_valid, 1);
        check("midrst_pre_busy", busy, 1);
        rst = 1'b1;
        at_neg();
        check("midrst_rsp_valid", rsp_valid, 0);
        check("midrst_busy", busy, 0);
        step();
        rst       = 1'b0;
        rsp_ready = 1'b1;
        pops      = 0;
        repeat (LAT + 6) step();
        check("midrst_no_rsp", pops, 0);
        req_valid = '1;
        at_neg();
        check("midrst_first_grant", req_ready, 4'b0001);
        step();
        drain();

`ifdef AES_CIPHER_ARB_CHK_EN
        // spurious core valid with no tag in flight
        step();
        spur = 1'b1;
        step();
        spur = 1'b0;
        at_neg();
        check("chk_err_set", err, 1);
        check("chk_fifo_unchanged", rsp_valid, 0);
        repeat (5) step();
        check("chk_err_held", err, 1);
        do_reset();
        at_neg();
        check("chk_err_cleared", err, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
